// File: rtl/fetch_stage.sv
// fetch_stage -- IF stage of a single-issue in-order pipeline.
// Owns the PC, drives the instruction memory address combinationally and
// registers the fetched word into the IF/ID register for decode.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to reject redirect targets
// that are not word aligned. A rejected redirect holds the PC, inserts a
// bubble and pulses misalign_fault. Without the macro, the low two target
// bits are cleared and misalign_fault is tied low.
module fetch_stage #(
    parameter int                 A_WIDTH      = 32,
    parameter logic [A_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [1:0]         pc_src,
    input  logic [A_WIDTH-1:0] branch_target,
    input  logic [A_WIDTH-1:0] jalr_target,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        instr_d,
    output logic [A_WIDTH-1:0] pc_d,
    output logic [A_WIDTH-1:0] pc_plus4_d,
    output logic               valid_d,
    output logic [31:0]        fetch_count,
    output logic               misalign_fault
);

    localparam logic [31:0]        NOP    = 32'h00000013;
    localparam logic [A_WIDTH-1:0] PC_INC = A_WIDTH'(4);

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [31:0]        instr;
        logic [A_WIDTH-1:0] pc;
        logic [A_WIDTH-1:0] pc_plus4;
        logic               valid;
    } ifid_t;

    logic [A_WIDTH-1:0] pc_q;
    logic [A_WIDTH-1:0] pc_next;
    logic [A_WIDTH-1:0] pc_inc;
    logic [A_WIDTH-1:0] tgt_sel;
    logic [A_WIDTH-1:0] tgt_load;
    logic               redirect;
    logic               tgt_reject;
    logic               advance;
    ifid_t              ifid_q;
    ifid_t              ifid_next;
    logic [31:0]        count_q;

    // Fetch address is the PC itself; no extra latency to the memory
    assign imem_addr = pc_q;

    // Sequential increment wraps naturally at 2^A_WIDTH
    assign pc_inc = pc_q + PC_INC;

    // Only encodings 01 and 10 redirect; 11 behaves like sequential fetch
    assign redirect = (pc_src == 2'b01) || (pc_src == 2'b10);

    // Select the redirect target source
    always_comb begin
        tgt_sel = branch_target;
        if (pc_src == 2'b10) tgt_sel = jalr_target;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;

    // Unaligned targets are refused rather than silently rounded
    assign tgt_reject = redirect && (tgt_sel[1:0] != 2'b00);
    assign tgt_load   = tgt_sel;

    // Fault flag is high only for the edge that saw the rejected redirect
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= tgt_reject;
    end

    assign misalign_fault = fault_q;
`else
    assign tgt_reject     = 1'b0;
    assign tgt_load       = {tgt_sel[A_WIDTH-1:2], 2'b00};
    assign misalign_fault = 1'b0;
`endif

    // A real instruction is delivered only when nothing overrides the advance
    assign advance = !redirect && !flush && !stall;

    // Next PC: redirect/flush beat stall, stall beats sequential advance
    always_comb begin
        pc_next = pc_inc;
        if (redirect) begin
            pc_next = tgt_reject ? pc_q : tgt_load;
        end else if (flush) begin
            pc_next = pc_inc;
        end else if (stall) begin
            pc_next = pc_q;
        end
    end

    // Next IF/ID contents: bubble on redirect/flush, hold on stall
    always_comb begin
        ifid_next = ifid_q;
        if (redirect || flush) begin
            ifid_next.instr = NOP;
            ifid_next.valid = 1'b0;
        end else if (!stall) begin
            ifid_next.instr    = imem_dout;
            ifid_next.pc       = pc_q;
            ifid_next.pc_plus4 = pc_inc;
            ifid_next.valid    = 1'b1;
        end
    end

    // PC and IF/ID register update; reset discards any pending redirect/stall
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_VECTOR;
            ifid_q.instr    <= NOP;
            ifid_q.pc       <= '0;
            ifid_q.pc_plus4 <= '0;
            ifid_q.valid    <= 1'b0;
        end else begin
            pc_q   <= pc_next;
            ifid_q <= ifid_next;
        end
    end

    // Count every edge that hands a valid instruction to decode
    always_ff @(posedge clk) begin
        if (rst)          count_q <= '0;
        else if (advance) count_q <= count_q + 32'd1;
    end

    assign instr_d     = ifid_q.instr;
    assign pc_d        = ifid_q.pc;
    assign pc_plus4_d  = ifid_q.pc_plus4;
    assign valid_d     = ifid_q.valid;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A reference model tracks the PC and
// IF/ID state; every delivered instruction is pushed to a scoreboard when
// stimulus is driven and popped when the DUT presents it on the decode side.
module tb_fetch_stage;

    localparam int          AW  = 32;
    localparam logic [31:0] RV  = 32'hBFC00000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] branch_target = '0;
    logic [31:0] jalr_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic [31:0] fetch_count;
    logic        misalign_fault;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_cnt;
    logic        m_valid, m_fault;

    // instruction memory contents: a fixed function of the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5EED1234;
    endfunction

    assign imem_dout = mem(imem_addr);

    always #5 clk = ~clk;

    fetch_stage #(.A_WIDTH(AW), .RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_src(pc_src),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .imem_addr(imem_addr), .imem_dout(imem_dout), .instr_d(instr_d),
        .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .fetch_count(fetch_count), .misalign_fault(misalign_fault)
    );

    // Drive one cycle of inputs, advance the model, wait for the edge + 1
    task automatic step(input logic r, input logic st, input logic fl,
                        input logic [1:0] src, input logic [31:0] bt,
                        input logic [31:0] jt, output logic adv);
        logic        redir;
        logic [31:0] tgt;
        rst = r; stall = st; flush = fl; pc_src = src;
        branch_target = bt; jalr_target = jt;
        adv   = 1'b0;
        redir = (src == 2'b01) || (src == 2'b10);
        tgt   = (src == 2'b10) ? jt : bt;
        if (r) begin
            m_pc = RV; m_instr = NOP; m_valid = 1'b0; m_cnt = 0; m_fault = 1'b0;
            exp_q.delete();
        end else begin
            m_fault = 1'b0;
            if (redir) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                if (tgt[1:0] != 2'b00) m_fault = 1'b1;
                else                   m_pc = tgt;
`else
                m_pc = {tgt[31:2], 2'b00};
`endif
                m_instr = NOP; m_valid = 1'b0;
            end else if (fl) begin
                m_instr = NOP; m_valid = 1'b0; m_pc = m_pc + 32'd4;
            end else if (!st) begin
                exp_q.push_back('{instr: mem(m_pc), pc: m_pc, pc4: m_pc + 32'd4});
                m_instr = mem(m_pc); m_valid = 1'b1; m_cnt = m_cnt + 1;
                m_pc = m_pc + 32'd4; adv = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
    endtask

    task automatic test_reset();
        logic adv;
        step(1'b1, 1'b1, 1'b1, 2'b01, 32'h12345678, 32'h0, adv);
        checks++; if (imem_addr !== RV) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, RV); end
        checks++; if ({instr_d, pc_d, pc_plus4_d} !== {NOP, 32'h0, 32'h0}) begin
            errors++; $display("FAIL reset_ifid got %h/%h/%h exp %h/0/0", instr_d, pc_d, pc_plus4_d, NOP); end
        checks++; if ({valid_d, misalign_fault, fetch_count} !== 34'h0) begin
            errors++; $display("FAIL reset_flags got v=%b f=%b cnt=%0d exp 0/0/0", valid_d, misalign_fault, fetch_count); end
    endtask

    task automatic test_free_run();
        logic adv;
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv);
            checks++; if (imem_addr !== RV + 32'(4 * i)) begin
                errors++; $display("FAIL run_addr%0d got %h exp %h", i, imem_addr, RV + 32'(4 * i)); end
            checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL run_valid%0d got %b exp 1", i, valid_d); end
            if (adv) begin
                e = exp_q.pop_front();
                checks++; if ({instr_d, pc_d, pc_plus4_d} !== e) begin
                    errors++; $display("FAIL run_sb%0d got %h/%h/%h exp %h/%h/%h", i, instr_d, pc_d, pc_plus4_d, e.instr, e.pc, e.pc4); end
            end
        end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL run_count got %0d exp 3", fetch_count); end
    endtask

    task automatic test_stall();
        logic adv;
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv);
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv); void'(exp_q.pop_front());
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv); void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, adv);
            checks++; if ({imem_addr, pc_d, instr_d, fetch_count} !== {32'hBFC00008, 32'hBFC00004, mem(32'hBFC00004), 32'd2}) begin
                errors++; $display("FAIL stall_hold%0d got addr=%h pc_d=%h instr=%h cnt=%0d exp BFC00008/BFC00004/%h/2",
                                   i, imem_addr, pc_d, instr_d, fetch_count, mem(32'hBFC00004)); end
        end
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv);
        e = exp_q.pop_front();
        checks++; if ({pc_d, instr_d, fetch_count} !== {32'hBFC00008, e.instr, 32'd3}) begin
            errors++; $display("FAIL stall_release got pc_d=%h instr=%h cnt=%0d exp BFC00008/%h/3", pc_d, instr_d, fetch_count, e.instr); end
    endtask

    task automatic test_branch_stall();
        logic adv;
        step(1'b0, 1'b1, 1'b0, 2'b01, 32'hBFC00100, 32'h0, adv);
        checks++; if ({imem_addr, instr_d, valid_d} !== {32'hBFC00100, NOP, 1'b0}) begin
            errors++; $display("FAIL branch_redir got addr=%h instr=%h v=%b exp BFC00100/%h/0", imem_addr, instr_d, valid_d, NOP); end
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv);
        e = exp_q.pop_front();
        checks++; if ({pc_d, valid_d, instr_d} !== {32'hBFC00100, 1'b1, e.instr}) begin
            errors++; $display("FAIL branch_deliver got pc_d=%h v=%b instr=%h exp BFC00100/1/%h", pc_d, valid_d, instr_d, e.instr); end
    endtask

    task automatic test_wrap();
        logic adv;
        step(1'b0, 1'b0, 1'b0, 2'b01, 32'hFFFFFFFC, 32'h0, adv);
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv);
        void'(exp_q.pop_front());
        checks++; if ({imem_addr, pc_d, pc_plus4_d} !== {32'h0, 32'hFFFFFFFC, 32'h0}) begin
            errors++; $display("FAIL wrap got addr=%h pc_d=%h pc4=%h exp 0/FFFFFFFC/0", imem_addr, pc_d, pc_plus4_d); end
    endtask

    task automatic test_misalign();
        logic adv;
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv);
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv); void'(exp_q.pop_front());
        step(1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'hBFC00102, adv);
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++; if ({imem_addr, misalign_fault, valid_d} !== {32'hBFC00004, 1'b1, 1'b0}) begin
            errors++; $display("FAIL misalign_reject got addr=%h f=%b v=%b exp BFC00004/1/0", imem_addr, misalign_fault, valid_d); end
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv); void'(exp_q.pop_front());
        checks++; if ({misalign_fault, pc_d} !== {1'b0, 32'hBFC00004}) begin
            errors++; $display("FAIL misalign_pulse got f=%b pc_d=%h exp 0/BFC00004", misalign_fault, pc_d); end
`else
        checks++; if ({imem_addr, misalign_fault, valid_d} !== {32'hBFC00100, 1'b0, 1'b0}) begin
            errors++; $display("FAIL misalign_round got addr=%h f=%b v=%b exp BFC00100/0/0", imem_addr, misalign_fault, valid_d); end
`endif
    endtask

    task automatic test_flush();
        logic        adv;
        logic [31:0] prev;
        prev = imem_addr;
        step(1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0, adv);
        checks++; if ({imem_addr, instr_d, valid_d} !== {prev + 32'd4, NOP, 1'b0}) begin
            errors++; $display("FAIL flush got addr=%h instr=%h v=%b exp %h/%h/0", imem_addr, instr_d, valid_d, prev + 32'd4, NOP); end
    endtask

    task automatic test_back_to_back();
        logic        adv, st, fl;
        logic [1:0]  src;
        logic [31:0] bt, jt;
        for (int i = 0; i < 80; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bt  = $urandom & 32'hFFFFFFFC;
            jt  = ($urandom & 32'hFFFFFFFC) | (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
            step(1'b0, st, fl, src, bt, jt, adv);
            checks++; if ({imem_addr, instr_d, valid_d, fetch_count, misalign_fault} !== {m_pc, m_instr, m_valid, m_cnt, m_fault}) begin
                errors++; $display("FAIL b2b_state%0d got %h/%h/%b/%0d/%b exp %h/%h/%b/%0d/%b", i, imem_addr, instr_d,
                                   valid_d, fetch_count, misalign_fault, m_pc, m_instr, m_valid, m_cnt, m_fault); end
            if (adv) begin
                e = exp_q.pop_front();
                checks++; if ({instr_d, pc_d, pc_plus4_d} !== e) begin
                    errors++; $display("FAIL b2b_sb%0d got %h/%h/%h exp %h/%h/%h", i, instr_d, pc_d, pc_plus4_d, e.instr, e.pc, e.pc4); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic adv;
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv); if (adv) void'(exp_q.pop_front());
        step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, adv);
        step(1'b1, 1'b1, 1'b1, 2'b01, 32'h00001000, 32'h0, adv);
        checks++; if ({imem_addr, instr_d, pc_d, pc_plus4_d} !== {RV, NOP, 32'h0, 32'h0}) begin
            errors++; $display("FAIL rstmid_ifid got %h/%h/%h/%h exp %h/%h/0/0", imem_addr, instr_d, pc_d, pc_plus4_d, RV, NOP); end
        checks++; if ({valid_d, misalign_fault, fetch_count} !== 34'h0) begin
            errors++; $display("FAIL rstmid_flags got v=%b f=%b cnt=%0d exp 0/0/0", valid_d, misalign_fault, fetch_count); end
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, adv);
        e = exp_q.pop_front();
        checks++; if ({pc_d, instr_d, fetch_count} !== {RV, e.instr, 32'd1}) begin
            errors++; $display("FAIL rstmid_first got pc_d=%h instr=%h cnt=%0d exp %h/%h/1", pc_d, instr_d, fetch_count, RV, e.instr); end
    endtask

    initial begin
        #1;
        test_reset();
        test_free_run();
        test_stall();
        test_branch_stall();
        test_wrap();
        test_misalign();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
